// File: rtl/mem_moc_responder_pkg.sv
// Shared codes, FSM states and byte-lane helpers for the MOV/MOC
// memory responder and its byte array.
package mem_moc_responder_pkg;

   typedef enum logic [1:0] {
      DT_BYTE = 2'b00,
      DT_HALF = 2'b01,
      DT_WORD = 2'b10,
      DT_RSVD = 2'b11
   } dt_e;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Request fields latched when MOV is first seen in IDLE.
   typedef struct packed {
      logic        rw;
      dt_e         dt;
      logic [31:0] wdata;
   } req_t;

   // Byte needs nothing, half needs an even address, word/reserved
   // need a word boundary.
   function automatic logic is_aligned(input dt_e dt,
                                       input logic [1:0] lsb);
      logic ok;
      case (dt)
         DT_BYTE: ok = 1'b1;
         DT_HALF: ok = ~lsb[0];
         default: ok = (lsb == 2'b00);
      endcase
      return ok;
   endfunction

   // Lane 3 (bits 31:24) is the byte at the base address.
   function automatic logic [3:0] lane_we(input dt_e dt);
      logic [3:0] we;
      case (dt)
         DT_BYTE: we = 4'b1000;
         DT_HALF: we = 4'b1100;
         default: we = 4'b1111;
      endcase
      return we;
   endfunction

   // Right-justified MDR data moved up to the big-endian lanes.
   function automatic logic [31:0] lane_wdata(input dt_e dt,
                                              input logic [31:0] d);
      logic [31:0] w;
      case (dt)
         DT_BYTE: w = {d[7:0], 24'h0};
         DT_HALF: w = {d[15:0], 16'h0};
         default: w = d;
      endcase
      return w;
   endfunction

   // Big-endian lanes brought down to zero-extended read data.
   function automatic logic [31:0] lane_rdata(input dt_e dt,
                                              input logic [31:0] l);
      logic [31:0] r;
      case (dt)
         DT_BYTE: r = {24'h0, l[31:24]};
         DT_HALF: r = {16'h0, l[31:16]};
         default: r = l;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-wide storage with four combinational read lanes starting at a
// base address and a per-lane synchronous write enable.
module mem_byte_array #(
   parameter int ADDR_W = 8
) (
   input  logic              i_clk,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [3:0]        i_we,
   input  logic [31:0]       i_wdata,
   output logic [31:0]       o_rdata
);

   localparam int DEPTH = 2**ADDR_W;

   logic [7:0]        r_mem [DEPTH];
   logic [ADDR_W-1:0] w_lane_addr [4];

   for (genvar k = 0; k < 4; k++) begin : g_lane
      assign w_lane_addr[k] = i_addr + ADDR_W'(k);
      assign o_rdata[31-8*k -: 8] = r_mem[w_lane_addr[k]];
   end

   // Only lanes with their enable set are updated; contents survive reset.
   always_ff @(posedge i_clk) begin
      for (int k = 0; k < 4; k++) begin
         if (i_we[3-k]) begin
            r_mem[w_lane_addr[k]] <= i_wdata[31-8*k -: 8];
         end
      end
   end

endmodule

// File: rtl/mem_moc_responder.sv
// Memory-side responder for the CU's MOV/MOC handshake: captures a
// request, waits, performs a big-endian access, holds MOC until MOV drops.
module mem_moc_responder #(
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              MOV,
   input  logic              RW,
   input  logic [1:0]        DT,
   input  logic [ADDR_W-1:0] ADDR,
   input  logic [31:0]       DATA_IN,
   output logic [31:0]       DATA_OUT,
   output logic              MOC,
   output logic              ALIGN_ERR
);

   import mem_moc_responder_pkg::*;

   localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

   state_e            r_state;
   logic [3:0]        r_cnt;
   req_t              r_req;
   logic [ADDR_W-1:0] r_addr;

   logic        w_aligned;
   logic        w_fire;
   logic [3:0]  w_we;
   logic [31:0] w_wlanes;
   logic [31:0] w_rlanes;
   logic [31:0] w_rdata;

   mem_byte_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .i_clk   (CLK),
      .i_addr  (r_addr),
      .i_we    (w_we),
      .i_wdata (w_wlanes),
      .o_rdata (w_rlanes)
   );

   // Alignment check and lane steering on the captured request.
   always_comb begin
      w_aligned = is_aligned(r_req.dt, r_addr[1:0]);
      w_fire    = (r_state == ST_BUSY) && MOV && (r_cnt == 4'd0);
      w_we      = 4'b0000;
      if (w_fire && w_aligned && (r_req.rw == RW_WRITE)) begin
         w_we = lane_we(r_req.dt);
      end
      w_wlanes = lane_wdata(r_req.dt, r_req.wdata);
      w_rdata  = w_aligned ? lane_rdata(r_req.dt, w_rlanes) : 32'h0;
   end

   // Handshake FSM with wait counter and registered MOC/DATA_OUT/ALIGN_ERR.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state   <= ST_IDLE;
         r_cnt     <= 4'd0;
         r_req     <= '0;
         r_addr    <= '0;
         MOC       <= 1'b0;
         DATA_OUT  <= 32'h0;
         ALIGN_ERR <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (MOV) begin
                  r_req   <= '{rw: RW, dt: dt_e'(DT), wdata: DATA_IN};
                  r_addr  <= ADDR;
                  r_cnt   <= LP_WAIT;
                  r_state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (!MOV) begin
                  r_state <= ST_IDLE;
               end else if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  MOC       <= 1'b1;
                  ALIGN_ERR <= ~w_aligned;
                  if (r_req.rw == RW_READ) begin
                     DATA_OUT <= w_rdata;
                  end
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (!MOV) begin
                  MOC       <= 1'b0;
                  ALIGN_ERR <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            end
            default: begin
               MOC       <= 1'b0;
               ALIGN_ERR <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_moc_responder.sv
// Self-checking bench for mem_moc_responder: directed table, hand-built
// handshake corner cases and random traffic against a byte-array model.
module tb_mem_moc_responder;

   localparam int WAIT = 2;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        MOV;
   logic        RW;
   logic [1:0]  DT;
   logic [7:0]  ADDR;
   logic [31:0] DATA_IN;
   logic [31:0] DATA_OUT;
   logic        MOC;
   logic        ALIGN_ERR;

   logic        Z_MOV;
   logic        Z_RW;
   logic [1:0]  Z_DT;
   logic [7:0]  Z_ADDR;
   logic [31:0] Z_DATA_IN;
   logic [31:0] Z_DATA_OUT;
   logic        Z_MOC;
   logic        Z_ALIGN_ERR;

   int errors = 0;
   int checks = 0;

   logic [7:0]  m_mem [256];
   logic [31:0] m_last;

   typedef struct {
      logic        rw;
      logic [1:0]  dt;
      logic [7:0]  a;
      logic [31:0] d;
      logic [31:0] q;
      logic        e;
   } vec_t;

   vec_t tv [18];

   mem_moc_responder #(
      .ADDR_W      (8),
      .WAIT_CYCLES (WAIT)
   ) u_dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .MOV       (MOV),
      .RW        (RW),
      .DT        (DT),
      .ADDR      (ADDR),
      .DATA_IN   (DATA_IN),
      .DATA_OUT  (DATA_OUT),
      .MOC       (MOC),
      .ALIGN_ERR (ALIGN_ERR)
   );

   mem_moc_responder #(
      .ADDR_W      (8),
      .WAIT_CYCLES (0)
   ) u_dut0 (
      .CLK       (CLK),
      .RESET     (RESET),
      .MOV       (Z_MOV),
      .RW        (Z_RW),
      .DT        (Z_DT),
      .ADDR      (Z_ADDR),
      .DATA_IN   (Z_DATA_IN),
      .DATA_OUT  (Z_DATA_OUT),
      .MOC       (Z_MOC),
      .ALIGN_ERR (Z_ALIGN_ERR)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, got, exp);
      end
   endtask

   // Reference: memory as a plain byte array, access size from DT.
   task automatic model_op(input logic rw, input logic [1:0] dt,
                           input logic [7:0] a, input logic [31:0] d,
                           output logic [31:0] q, output logic e);
      int sz;
      sz = (dt == 2'd0) ? 1 : (dt == 2'd1) ? 2 : 4;
      e = (int'(a) % sz) != 0;
      if (rw) begin
         m_last = 32'h0;
         if (!e) begin
            for (int i = 0; i < sz; i++) begin
               m_last = (m_last << 8) | 32'(m_mem[8'(int'(a) + i)]);
            end
         end
      end else if (!e) begin
         for (int i = 0; i < sz; i++) begin
            m_mem[8'(int'(a) + i)] = 8'(d >> (8 * (sz - 1 - i)));
         end
      end
      q = m_last;
   endtask

   task automatic start_req(input logic rw, input logic [1:0] dt,
                            input logic [7:0] a, input logic [31:0] d);
      @(negedge CLK);
      MOV = 1'b1;
      RW = rw;
      DT = dt;
      ADDR = a;
      DATA_IN = d;
   endtask

   // Counts edges after the capture edge until MOC; scrambles inputs
   // right after capture.
   task automatic wait_moc(output int lat);
      lat = -1;
      for (int n = 0; n < 40; n++) begin
         @(posedge CLK);
         #1;
         if (n == 0) begin
            RW = 1'($urandom);
            DT = 2'($urandom);
            ADDR = 8'($urandom);
            DATA_IN = $urandom;
         end
         if (MOC) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic drop(input string tag, input logic [31:0] eq);
      @(negedge CLK);
      MOV = 1'b0;
      @(posedge CLK);
      #1;
      chk({tag, "_mocfall"}, 32'(MOC), 32'd0);
      chk({tag, "_errfall"}, 32'(ALIGN_ERR), 32'd0);
      chk({tag, "_douthold"}, DATA_OUT, eq);
   endtask

   task automatic op_chk(input string tag, input logic rw,
                         input logic [1:0] dt, input logic [7:0] a,
                         input logic [31:0] d, input logic [31:0] eq,
                         input logic ee);
      int lat;
      start_req(rw, dt, a, d);
      wait_moc(lat);
      chk({tag, "_lat"}, 32'(lat), 32'(1 + WAIT));
      chk({tag, "_dout"}, DATA_OUT, eq);
      chk({tag, "_err"}, 32'(ALIGN_ERR), 32'(ee));
      drop(tag, eq);
   endtask

   initial begin
      logic [31:0] q;
      logic        e;
      logic        rw;
      logic [1:0]  dt;
      logic [7:0]  a;
      logic [31:0] d;
      int          lat;
      int          zl;
      logic        seen;

      tv[0]  = '{1'b0, 2'b10, 8'h04, 32'hDEADBEEF, 32'h00000000, 1'b0};
      tv[1]  = '{1'b1, 2'b10, 8'h04, 32'h0,        32'hDEADBEEF, 1'b0};
      tv[2]  = '{1'b1, 2'b00, 8'h05, 32'h0,        32'h000000AD, 1'b0};
      tv[3]  = '{1'b1, 2'b01, 8'h06, 32'h0,        32'h0000BEEF, 1'b0};
      tv[4]  = '{1'b0, 2'b00, 8'h07, 32'hFFFFFF12, 32'h0000BEEF, 1'b0};
      tv[5]  = '{1'b1, 2'b10, 8'h04, 32'h0,        32'hDEADBE12, 1'b0};
      tv[6]  = '{1'b0, 2'b01, 8'h04, 32'hFFFF3456, 32'hDEADBE12, 1'b0};
      tv[7]  = '{1'b1, 2'b10, 8'h04, 32'h0,        32'h3456BE12, 1'b0};
      tv[8]  = '{1'b1, 2'b10, 8'h06, 32'h0,        32'h00000000, 1'b1};
      tv[9]  = '{1'b0, 2'b01, 8'h05, 32'h0000AAAA, 32'h00000000, 1'b1};
      tv[10] = '{1'b1, 2'b10, 8'h04, 32'h0,        32'h3456BE12, 1'b0};
      tv[11] = '{1'b1, 2'b11, 8'h04, 32'h0,        32'h3456BE12, 1'b0};
      tv[12] = '{1'b0, 2'b10, 8'hFC, 32'hCAFEF00D, 32'h3456BE12, 1'b0};
      tv[13] = '{1'b1, 2'b01, 8'hFE, 32'h0,        32'h0000F00D, 1'b0};
      tv[14] = '{1'b0, 2'b00, 8'hFF, 32'h0000005A, 32'h0000F00D, 1'b0};
      tv[15] = '{1'b1, 2'b01, 8'hFE, 32'h0,        32'h0000F05A, 1'b0};
      tv[16] = '{1'b1, 2'b10, 8'hFC, 32'h0,        32'hCAFEF05A, 1'b0};
      tv[17] = '{1'b1, 2'b01, 8'h03, 32'h0,        32'h00000000, 1'b1};

      RESET = 1'b1;
      MOV = 1'b0;
      RW = 1'b0;
      DT = 2'b00;
      ADDR = 8'h00;
      DATA_IN = 32'h0;
      Z_MOV = 1'b0;
      Z_RW = 1'b0;
      Z_DT = 2'b00;
      Z_ADDR = 8'h00;
      Z_DATA_IN = 32'h0;
      m_last = 32'h0;
      for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;

      repeat (3) @(negedge CLK);
      RESET = 1'b0;
      @(posedge CLK);
      #1;
      chk("rst_moc", 32'(MOC), 32'd0);
      chk("rst_dout", DATA_OUT, 32'h0);
      chk("rst_err", 32'(ALIGN_ERR), 32'd0);
      chk("rst_moc0", 32'(Z_MOC), 32'd0);

      // Give every array byte a known value.
      for (int w = 0; w < 64; w++) begin
         d = $urandom;
         model_op(1'b0, 2'b10, 8'(4 * w), d, q, e);
         op_chk("fill", 1'b0, 2'b10, 8'(4 * w), d, q, e);
      end

      for (int i = 0; i < 18; i++) begin
         model_op(tv[i].rw, tv[i].dt, tv[i].a, tv[i].d, q, e);
         op_chk($sformatf("tv%0d", i), tv[i].rw, tv[i].dt, tv[i].a,
                tv[i].d, tv[i].q, tv[i].e);
      end

      // MOV dropped while BUSY: no write, no MOC.
      start_req(1'b0, 2'b10, 8'h20, 32'h0BADF00D);
      @(posedge CLK);
      #1;
      @(negedge CLK);
      MOV = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(posedge CLK);
         #1;
         if (MOC) seen = 1'b1;
      end
      chk("abort_moc", 32'(seen), 32'd0);
      model_op(1'b1, 2'b10, 8'h20, 32'h0, q, e);
      op_chk("abort_rd", 1'b1, 2'b10, 8'h20, 32'h0, q, e);

      // RESET while BUSY drops the pending write.
      start_req(1'b0, 2'b10, 8'h28, 32'h11223344);
      @(posedge CLK);
      #1;
      @(negedge CLK);
      RESET = 1'b1;
      #1;
      chk("rstbusy_moc", 32'(MOC), 32'd0);
      chk("rstbusy_dout", DATA_OUT, 32'h0);
      @(negedge CLK);
      RESET = 1'b0;
      MOV = 1'b0;
      m_last = 32'h0;
      model_op(1'b1, 2'b10, 8'h28, 32'h0, q, e);
      op_chk("rstbusy_rd", 1'b1, 2'b10, 8'h28, 32'h0, q, e);

      // RESET in DONE: write already landed, outputs clear at once.
      start_req(1'b0, 2'b10, 8'h24, 32'h55667788);
      wait_moc(lat);
      chk("rstdone_lat", 32'(lat), 32'(1 + WAIT));
      model_op(1'b0, 2'b10, 8'h24, 32'h55667788, q, e);
      @(negedge CLK);
      RESET = 1'b1;
      #1;
      chk("rstdone_moc", 32'(MOC), 32'd0);
      chk("rstdone_err", 32'(ALIGN_ERR), 32'd0);
      chk("rstdone_dout", DATA_OUT, 32'h0);
      @(negedge CLK);
      RESET = 1'b0;
      MOV = 1'b0;
      m_last = 32'h0;
      model_op(1'b1, 2'b10, 8'h24, 32'h0, q, e);
      op_chk("rstdone_rd", 1'b1, 2'b10, 8'h24, 32'h0, q, e);

      // MOV held long after MOC: MOC stays, no second access.
      start_req(1'b0, 2'b10, 8'h30, 32'h0F1E2D3C);
      wait_moc(lat);
      chk("hold_lat", 32'(lat), 32'(1 + WAIT));
      for (int h = 0; h < 10; h++) begin
         @(negedge CLK);
         RW = 1'b0;
         ADDR = 8'h34;
         DATA_IN = $urandom;
         @(posedge CLK);
         #1;
         chk("hold_moc", 32'(MOC), 32'd1);
      end
      model_op(1'b0, 2'b10, 8'h30, 32'h0F1E2D3C, q, e);
      drop("hold", q);
      model_op(1'b1, 2'b10, 8'h34, 32'h0, q, e);
      op_chk("hold_rd34", 1'b1, 2'b10, 8'h34, 32'h0, q, e);
      model_op(1'b1, 2'b10, 8'h30, 32'h0, q, e);
      op_chk("hold_rd30", 1'b1, 2'b10, 8'h30, 32'h0, q, e);

      // Zero-wait build: MOC one edge after capture.
      for (int k = 0; k < 2; k++) begin
         @(negedge CLK);
         Z_MOV = 1'b1;
         Z_RW = (k == 1);
         Z_DT = 2'b10;
         Z_ADDR = 8'h10;
         Z_DATA_IN = 32'hA5A55A5A;
         zl = -1;
         for (int n = 0; n < 20; n++) begin
            @(posedge CLK);
            #1;
            if (Z_MOC) begin
               zl = n;
               break;
            end
         end
         chk("w0_lat", 32'(zl), 32'd1);
         if (k == 1) chk("w0_rd", Z_DATA_OUT, 32'hA5A55A5A);
         @(negedge CLK);
         Z_MOV = 1'b0;
         @(posedge CLK);
         #1;
         chk("w0_fall", 32'(Z_MOC), 32'd0);
      end

      // Random traffic, including misaligned and reserved-type requests.
      for (int r = 0; r < 150; r++) begin
         rw = 1'($urandom);
         dt = 2'($urandom);
         a = 8'($urandom);
         d = $urandom;
         model_op(rw, dt, a, d, q, e);
         op_chk($sformatf("rnd%0d", r), rw, dt, a, d, q, e);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
